instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous reset, active high.
REQ-002 The block SHALL have these inputs: inst_in  in  8  fetched instruction byte; mem_ready  in  1  memory handshake complete; irq  in  1  level interrupt request; ei  in  1  enable-interrupts pulse; cli  in  1  clear-interrupt strobe from the decoder.
REQ-003 The block SHALL have these outputs: ir  out  8  instruction register to the decoder; cycle  out  1  decoder phase; fetch  out  1  fetch request; pc_en  out  1  PC increment pulse; retire  out  1  instruction-complete pulse; irq_ack  out  1  interrupt-taken pulse; ie  out  1  interrupt-enable flag; state  out  2  state for debug.

Function
REQ-004 The FSM SHALL have four states, encoded on state: FETCH=0, EX0=1, EX1=2, INT=3.
REQ-005 In FETCH: fetch=1 and cycle=0; no other pulse outputs are asserted.
REQ-006 In FETCH with mem_ready=1 and no interrupt pending, ir SHALL load inst_in, pc_en SHALL pulse for that cycle, and the next state SHALL be EX0.
REQ-007 In FETCH with mem_ready=0, the FSM SHALL hold, and ir and pc SHALL be unchanged.
REQ-008 Interrupt pending = irq & ie; it SHALL be sampled only in FETCH, SHALL take priority over mem_ready, and SHALL move the FSM to INT without loading ir.
REQ-009 In EX0: cycle=0. If ir[7]=0, retire SHALL pulse and the next state SHALL be FETCH. If ir[7]=1, the next state SHALL be EX1 with no retire.
REQ-010 In EX1: cycle=1. Memory instructions (ir[7]=1, ir[6]=0) SHALL hold in EX1 until mem_ready=1. Then retire SHALL pulse and the next state SHALL be FETCH.
REQ-011 Jump-class instructions (ir[7:6]=11) SHALL leave EX1 after exactly one cycle, regardless of mem_ready.
REQ-012 In INT: irq_ack SHALL pulse for one cycle, ie SHALL clear, and the next state SHALL be FETCH. Neither pc_en nor retire SHALL assert.
REQ-013 ie SHALL set on ei=1 and clear on cli=1 while the FSM is in EX0. If ei and cli are both high, cli SHALL win. INT clears ie regardless of ei.
REQ-014 Latency:
- Non-ir[7] instruction: 2 cycles (FETCH+EX0) with zero-wait memory.
- ir[7] instruction: 3 cycles plus wait cycles.
REQ-015 All outputs SHALL be registered state-decoded values or Moore decodes of state/ir. No output SHALL depend combinationally on inst_in.
REQ-016 Pulse outputs (pc_en, retire, irq_ack) SHALL never assert in the same cycle as each other.

Reset
REQ-017 While rst=1, these SHALL hold regardless of clk:
- state = FETCH
- ir = 8'h00
- ie = 0
- cycle = 0
- fetch = 1
- pc_en = 0, retire = 0, irq_ack = 0
REQ-018 A reset asserted mid-instruction (EX0, EX1 or INT) SHALL abandon that instruction without a retire or irq_ack pulse.
REQ-019 After rst deasserts, the first active clk edge SHALL evaluate FETCH normally.

Configuration
REQ-020 Macro SEQ_IRQ_EN defined: INT state, ie, ei/cli handling and irq_ack SHALL behave as specified above.
REQ-021 Macro SEQ_IRQ_EN undefined:
- irq, ei and cli SHALL be ignored.
- ie and irq_ack SHALL be tied 0.
- State INT SHALL be unreachable; if state=3 is ever entered, the next state SHALL be FETCH.

Verification
REQ-022 Reset, then inst_in=8'h12 with mem_ready=1: ir=8'h12 and pc_en=1 in cycle 1; retire=1 in cycle 2; state=0 in cycle 3.
REQ-023 inst_in=8'h85, with mem_ready low for 3 cycles in EX1: cycle=1 for 4 cycles, exactly one retire, pc_en=1 once.
REQ-024 inst_in=8'hE0: sequence FETCH->EX0->EX1->FETCH, cycle=0,0,1,0, with mem_ready=0 throughout EX1.
REQ-025 ei pulsed in EX0, then irq=1 with mem_ready=1 in FETCH: INT entered, irq_ack=1 for one cycle, ie=0 after, ir unchanged, pc_en=0.
REQ-026 In EX0, apply ei=1 and cli=1 together: ie=0. Then rst mid-EX1: no retire, state=0, ir=8'h00.
REQ-027 Build without SEQ_IRQ_EN, irq=1, ei pulsed: ie=0 and irq_ack=0 throughout, and instructions retire as in REQ-022.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction fetch/execute sequencer: FETCH -> EX0 -> [EX1] -> FETCH, with an optional INT state.
// Interrupt support (INT state, ie, ei/cli, irq_ack) is compiled in only when SEQ_IRQ_EN is defined.
module instr_sequencer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_inst_in,
  input  logic       i_mem_ready,
  input  logic       i_irq,
  input  logic       i_ei,
  input  logic       i_cli,
  output logic [7:0] o_ir,
  output logic       o_cycle,
  output logic       o_fetch,
  output logic       o_pc_en,
  output logic       o_retire,
  output logic       o_irq_ack,
  output logic       o_ie,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EX0   = 2'd1,
    S_EX1   = 2'd2,
    S_INT   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_ir;
  logic       r_ie;
  logic       r_pc_en;
  logic       r_retire;
  logic       r_irq_ack;
  logic       w_ie_next;
  logic       w_load_ir;
  logic       w_pc_en;
  logic       w_retire;
  logic       w_irq_ack;
  logic       w_pending;

`ifdef SEQ_IRQ_EN
  assign w_pending = i_irq & r_ie;
`else
  // Interrupt inputs are deliberately ignored in this build.
  logic w_unused;
  assign w_unused  = ^{i_irq, i_ei, i_cli};
  assign w_pending = 1'b0;
`endif

  // Next-state and pulse decode; pulses are registered one cycle later.
  always_comb begin
    w_next    = r_state;
    w_load_ir = 1'b0;
    w_pc_en   = 1'b0;
    w_retire  = 1'b0;
    w_irq_ack = 1'b0;
    w_ie_next = r_ie;
    case (r_state)
      S_FETCH: begin
        if (w_pending) begin
          w_next = S_INT;
        end else if (i_mem_ready) begin
          w_load_ir = 1'b1;
          w_pc_en   = 1'b1;
          w_next    = S_EX0;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_EX0: begin
`ifdef SEQ_IRQ_EN
        // cli wins over a simultaneous ei.
        if (i_cli) begin
          w_ie_next = 1'b0;
        end else if (i_ei) begin
          w_ie_next = 1'b1;
        end else begin
          w_ie_next = r_ie;
        end
`endif
        if (r_ir[7]) begin
          w_next = S_EX1;
        end else begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EX1: begin
        // Jump class (ir[6]=1) leaves after one cycle; memory class waits for mem_ready.
        if (r_ir[6] | i_mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_EX1;
        end
      end
      S_INT: begin
`ifdef SEQ_IRQ_EN
        w_irq_ack = 1'b1;
        w_ie_next = 1'b0;
`endif
        w_next = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // State, instruction register, interrupt enable and registered pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_ir      <= 8'h00;
      r_ie      <= 1'b0;
      r_pc_en   <= 1'b0;
      r_retire  <= 1'b0;
      r_irq_ack <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ie      <= w_ie_next;
      r_pc_en   <= w_pc_en;
      r_retire  <= w_retire;
      r_irq_ack <= w_irq_ack;
      if (w_load_ir) begin
        r_ir <= i_inst_in;
      end else begin
        r_ir <= r_ir;
      end
    end
  end

  assign o_ir      = r_ir;
  assign o_state   = r_state;
  assign o_cycle   = (r_state == S_EX1);
  assign o_fetch   = (r_state == S_FETCH);
  assign o_pc_en   = r_pc_en;
  assign o_retire  = r_retire;
  assign o_irq_ack = r_irq_ack;
  assign o_ie      = r_ie;

endmodule
